// File: rtl/half_bridge_pkg.sv
// Shared types and elaboration helpers for the half-bridge controller.
//   hb_state_t    : controller state encoding (IDLE / RUN / FAULT)
//   hb_params_ok  : returns 1 when PERIOD/DEAD/CW form a legal combination
package half_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } hb_state_t;

    // DEAD must leave room for both dead bands inside one period, and the
    // period index (0..PERIOD-1) must fit in the CW-bit counter.
    function automatic bit hb_params_ok(input int cw, input int period, input int dead);
        return (dead >= 1) && (2 * dead < period) && (period <= (1 << cw));
    endfunction

endpackage

// File: rtl/oc_detect.sv
// Overcurrent comparator: purely combinational |i_smp| > oc_lim check.
// Ports:
//   i_smp  : signed load-current sample (IW bits, two's complement)
//   i_vld  : sample valid
//   oc_lim : unsigned magnitude limit (IW-1 bits)
//   trip   : high while a valid sample exceeds the limit
module oc_detect #(
    parameter int IW = 12
) (
    input  logic [IW-1:0] i_smp,
    input  logic          i_vld,
    input  logic [IW-2:0] oc_lim,
    output logic          trip
);

    logic [IW-1:0] mag;

    // Magnitude kept in IW bits unsigned so the most negative code maps to
    // 2^(IW-1) instead of wrapping back to itself.
    always_comb begin
        mag  = i_smp[IW-1] ? ((~i_smp) + IW'(1)) : i_smp;
        trip = i_vld && (mag > {1'b0, oc_lim});
    end

endmodule

// File: rtl/half_bridge_ctrl.sv
// Half-bridge gate sequencer: complementary gates from a fixed-period PWM
// counter with dead time, double-buffered duty and latched overcurrent fault.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   en                    : run request (level)
//   duty/duty_vld/duty_rdy: duty handshake into the shadow register
//   i_smp/i_vld/oc_lim    : current sample, valid, overcurrent limit
//   fault_clr             : clears a latched fault
//   gate_hi/gate_lo       : registered gate drives
//   fault                 : latched overcurrent
//   period_start          : one-cycle pulse in period index 0
//
// state | meaning
// IDLE  | gates off, waiting for en
// RUN   | PWM counting, gates decoded from period index and active duty
// FAULT | overcurrent latched, gates off until fault_clr
module half_bridge_ctrl
    import half_bridge_pkg::*;
#(
    parameter int CW     = 10,
    parameter int PERIOD = 1000,
    parameter int DEAD   = 8,
    parameter int IW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] duty,
    input  logic          duty_vld,
    output logic          duty_rdy,
    input  logic [IW-1:0] i_smp,
    input  logic          i_vld,
    input  logic [IW-2:0] oc_lim,
    input  logic          fault_clr,
    output logic          gate_hi,
    output logic          gate_lo,
    output logic          fault,
    output logic          period_start
);

    if (!hb_params_ok(CW, PERIOD, DEAD)) begin : g_bad_params
        $error("half_bridge_ctrl: illegal CW/PERIOD/DEAD combination");
    end

    localparam logic [CW-1:0] P_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] P_CLAMP = CW'(PERIOD);
    localparam logic [CW:0]   PER_X  = (CW + 1)'(PERIOD);
    localparam logic [CW:0]   DEAD_X = (CW + 1)'(DEAD);

    hb_state_t     state_q, state_d;
    logic [CW-1:0] p_q, p_d;
    logic [CW-1:0] d_q, d_d;
    logic [CW-1:0] sh_q, sh_d;
    logic          rdy_d;
    logic          trip, xfer, copy;
    logic          hi_d, lo_d, ps_d;

    oc_detect #(.IW(IW)) u_oc (
        .i_smp  (i_smp),
        .i_vld  (i_vld),
        .oc_lim (oc_lim),
        .trip   (trip)
    );

    assign xfer = duty_vld && duty_rdy;

    always_comb begin
        state_d = state_q;
        p_d     = '0;
        d_d     = d_q;
        sh_d    = sh_q;
        rdy_d   = duty_rdy;
        copy    = 1'b0;

        unique case (state_q)
            IDLE:  if (en) state_d = RUN;
            RUN: begin
                if (!en) state_d = IDLE;
                if (p_q != P_LAST) p_d = p_q + CW'(1);
            end
            FAULT: if (fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (trip) state_d = FAULT;
        if (state_d != RUN) p_d = '0;

        // Full shadow moves to the active duty at a period boundary or on run
        // entry. A transfer in the same cycle only refills the shadow.
        copy = !duty_rdy &&
               ((state_q == IDLE && state_d == RUN) || (state_q == RUN && p_q == P_LAST));
        if (copy) begin
            d_d   = sh_q;
            rdy_d = 1'b1;
        end
        if (xfer) begin
            sh_d  = ({1'b0, duty} > PER_X) ? P_CLAMP : duty;
            rdy_d = 1'b0;
        end

        // Gates are decoded from next-cycle values so the registered outputs
        // line up with the period index they belong to.
        hi_d = (state_d == RUN) && ({1'b0, p_d} >= DEAD_X) && ({1'b0, p_d} < {1'b0, d_d});
        lo_d = (state_d == RUN) && ({1'b0, p_d} >= ({1'b0, d_d} + DEAD_X)) &&
               ({1'b0, p_d} < PER_X);
        ps_d = (state_d == RUN) && (p_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            p_q          <= '0;
            d_q          <= '0;
            sh_q         <= '0;
            duty_rdy     <= 1'b1;
            gate_hi      <= 1'b0;
            gate_lo      <= 1'b0;
            fault        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            d_q          <= d_d;
            sh_q         <= sh_d;
            duty_rdy     <= rdy_d;
            gate_hi      <= hi_d;
            gate_lo      <= lo_d;
            fault        <= (state_d == FAULT);
            period_start <= ps_d;
        end
    end

endmodule

// File: tb/tb_half_bridge_ctrl.sv
module tb_half_bridge_ctrl;

    localparam int CW     = 10;
    localparam int PERIOD = 100;
    localparam int DEAD   = 4;
    localparam int IW     = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [CW-1:0] duty = '0;
    logic          duty_vld = 1'b0;
    logic          duty_rdy;
    logic [IW-1:0] i_smp = '0;
    logic          i_vld = 1'b0;
    logic [IW-2:0] oc_lim = 11'd1000;
    logic          fault_clr = 1'b0;
    logic          gate_hi, gate_lo, fault, period_start;

    half_bridge_ctrl #(.CW(CW), .PERIOD(PERIOD), .DEAD(DEAD), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty         (duty),
        .duty_vld     (duty_vld),
        .duty_rdy     (duty_rdy),
        .i_smp        (i_smp),
        .i_vld        (i_vld),
        .oc_lim       (oc_lim),
        .fault_clr    (fault_clr),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo),
        .fault        (fault),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic hi;
        logic lo;
        logic flt;
        logic ps;
        logic rdy;
    } obs_t;

    obs_t exp_q[$];

    localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;
    int m_state = M_IDLE, m_p = 0, m_d = 0, m_sh = 0;
    bit m_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = M_IDLE;
        m_p     = 0;
        m_d     = 0;
        m_sh    = 0;
        m_full  = 1'b0;
    endfunction

    // Cycle reference: next-cycle expected outputs pushed on every clock edge.
    function automatic void model_step();
        int   sv, mag, ns, np;
        bit   trip, xfer, cp;
        obs_t e;
        sv   = int'($signed(i_smp));
        mag  = (sv < 0) ? -sv : sv;
        trip = i_vld && (mag > int'(oc_lim));
        xfer = duty_vld && !m_full;
        case (m_state)
            M_IDLE:  ns = en ? M_RUN : M_IDLE;
            M_RUN:   ns = en ? M_RUN : M_IDLE;
            default: ns = fault_clr ? M_IDLE : M_FAULT;
        endcase
        if (trip) ns = M_FAULT;
        cp = m_full && ((m_state == M_IDLE && ns == M_RUN) ||
                        (m_state == M_RUN && m_p == PERIOD - 1));
        np = (ns == M_RUN && m_state == M_RUN) ? (m_p + 1) % PERIOD : 0;
        if (cp) begin
            m_d    = m_sh;
            m_full = 1'b0;
        end
        if (xfer) begin
            m_sh   = (int'(duty) > PERIOD) ? PERIOD : int'(duty);
            m_full = 1'b1;
        end
        m_state = ns;
        m_p     = np;
        e.hi  = (ns == M_RUN) && (np >= DEAD) && (np < m_d);
        e.lo  = (ns == M_RUN) && (np >= m_d + DEAD) && (np < PERIOD);
        e.flt = (ns == M_FAULT);
        e.ps  = (ns == M_RUN) && (np == 0);
        e.rdy = !m_full;
        exp_q.push_back(e);
    endfunction

    always @(posedge rst) begin
        model_reset();
        exp_q.delete();
    end

    always @(posedge clk) begin
        obs_t e;
        cyc++;
        if (rst) begin
            model_reset();
            e = '{hi: 1'b0, lo: 1'b0, flt: 1'b0, ps: 1'b0, rdy: 1'b1};
            exp_q.push_back(e);
        end else begin
            model_step();
        end
    end

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        obs_t e, o;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{hi: gate_hi, lo: gate_lo, flt: fault, ps: period_start, rdy: duty_rdy};
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL scoreboard cyc %0d: got hi=%b lo=%b fault=%b ps=%b rdy=%b, want hi=%b lo=%b fault=%b ps=%b rdy=%b",
                         cyc, o.hi, o.lo, o.flt, o.ps, o.rdy, e.hi, e.lo, e.flt, e.ps, e.rdy);
            end
            check("no_overlap", 32'(gate_hi & gate_lo), 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_p(input int k);
        for (int i = 0; i < 400; i++) begin
            if (m_state == M_RUN && m_p == k) return;
            tick();
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_p: period index %0d not reached, got state %0d p %0d", k, m_state, m_p);
    endtask

    task automatic gates_at(input int k, input bit hi, input bit lo);
        wait_p(k);
        check($sformatf("gate_hi@p%0d", k), 32'(gate_hi), 32'(hi));
        check($sformatf("gate_lo@p%0d", k), 32'(gate_lo), 32'(lo));
    endtask

    task automatic load_duty(input int v);
        duty     = CW'(v);
        duty_vld = 1'b1;
        tick();
        duty_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gate_hi"}, 32'(gate_hi), 0);
        check({tag, "_gate_lo"}, 32'(gate_lo), 0);
        check({tag, "_fault"}, 32'(fault), 0);
        check({tag, "_period_start"}, 32'(period_start), 0);
        check({tag, "_duty_rdy"}, 32'(duty_rdy), 1);
    endtask

    initial begin
        int t0;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Nominal duty 50
        load_duty(50);
        check("rdy_after_load", 32'(duty_rdy), 0);
        en = 1'b1;
        tick();
        check("ps_first", 32'(period_start), 1);
        check("rdy_after_copy", 32'(duty_rdy), 1);
        gates_at(3, 0, 0);
        gates_at(4, 1, 0);
        gates_at(49, 1, 0);
        gates_at(50, 0, 0);
        gates_at(53, 0, 0);
        gates_at(54, 0, 1);
        gates_at(99, 0, 1);
        wait_p(0);
        t0 = cyc;
        tick();
        wait_p(0);
        check("period_len", 32'(cyc - t0), 100);

        // Mid-period update to 30
        wait_p(20);
        load_duty(30);
        check("rdy_mid", 32'(duty_rdy), 0);
        gates_at(49, 1, 0);
        gates_at(50, 0, 0);
        wait_p(99);
        check("rdy_p99", 32'(duty_rdy), 0);
        tick();
        check("rdy_p0", 32'(duty_rdy), 1);
        check("ps_p0", 32'(period_start), 1);
        gates_at(4, 1, 0);
        gates_at(29, 1, 0);
        gates_at(30, 0, 0);
        gates_at(33, 0, 0);
        gates_at(34, 0, 1);

        // Duty 0
        wait_p(40);
        load_duty(0);
        gates_at(0, 0, 0);
        gates_at(3, 0, 0);
        gates_at(4, 0, 1);
        gates_at(99, 0, 1);

        // Clamp 150 -> 100, then 100 -> 0 boundary
        wait_p(10);
        load_duty(150);
        gates_at(3, 0, 0);
        gates_at(4, 1, 0);
        gates_at(50, 1, 0);
        wait_p(10);
        load_duty(0);
        gates_at(99, 1, 0);
        tick();
        check("b_hi_p0", 32'(gate_hi), 0);
        check("b_lo_p0", 32'(gate_lo), 0);
        gates_at(3, 0, 0);
        gates_at(4, 0, 1);

        // Overcurrent: limit boundary first, then a full-scale negative trip
        wait_p(5);
        i_smp = 12'h3E8;  // +1000
        i_vld = 1'b1;
        tick();
        i_smp = 12'hC18;  // -1000
        tick();
        i_smp = 12'h3E9;  // +1001 with no valid
        i_vld = 1'b0;
        tick();
        check("no_trip_at_limit", 32'(fault), 0);
        wait_p(10);
        i_smp = 12'h800;  // -2048
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        check("trip_fault", 32'(fault), 1);
        check("trip_hi", 32'(gate_hi), 0);
        check("trip_lo", 32'(gate_lo), 0);
        tick(5);
        check("fault_hold_en", 32'(fault), 1);
        fault_clr = 1'b1;
        i_vld = 1'b1;
        tick();
        check("clr_vs_trip", 32'(fault), 1);
        i_vld = 1'b0;
        i_smp = '0;
        tick();
        fault_clr = 1'b0;
        check("clr_fault", 32'(fault), 0);
        check("clr_ps", 32'(period_start), 0);
        tick();
        check("restart_ps", 32'(period_start), 1);
        gates_at(4, 0, 1);

        // en drop at p=60
        wait_p(60);
        check("pre_drop_lo", 32'(gate_lo), 1);
        en = 1'b0;
        tick();
        check("drop_hi", 32'(gate_hi), 0);
        check("drop_lo", 32'(gate_lo), 0);

        // Async reset at p=30 with D=70
        load_duty(70);
        en = 1'b1;
        tick();
        gates_at(30, 1, 0);
        #1 rst = 1'b1;
        #1;
        check("async_hi", 32'(gate_hi), 0);
        check("async_lo", 32'(gate_lo), 0);
        tick(2);
        rst = 1'b0;
        check_reset_outputs("post_rst");
        tick();
        check("post_rst_ps", 32'(period_start), 1);
        gates_at(3, 0, 0);
        gates_at(4, 0, 1);
        gates_at(70, 0, 1);

        en = 1'b0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/half_bridge_ctrl.md
# half_bridge_ctrl

Sequencing controller for the half-bridge that drives the series RLC load. Generates complementary high-side/low-side gate signals from a fixed-period PWM counter. Inserts dead time at every edge, double-buffers duty updates so they land only at period boundaries, and latches an overcurrent fault from sampled load current. Sits between the regulation loop (duty source, current ADC) and the gate drivers.

## Interface
Parameters:
- `CW`, 10: counter/duty width; `PERIOD` must be ≤ 2^CW.
- `PERIOD`, 1000: PWM period in clock cycles.
- `DEAD`, 8: dead time in cycles. Constraints: `DEAD` ≥ 1 and 2·`DEAD` < `PERIOD`.
- `IW`, 12: current sample width, two's complement.

Ports:
- `clk` in 1: clock. One clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run request, level.
- `duty` in CW: requested high-side interval, in cycles.
- `duty_vld` in 1: duty valid.
- `duty_rdy` out 1: duty shadow register empty.
- `i_smp` in IW: signed load-current sample.
- `i_vld` in 1: sample valid.
- `oc_lim` in IW-1: unsigned overcurrent magnitude limit.
- `fault_clr` in 1: clears a latched fault.
- `gate_hi` out 1: high-side gate.
- `gate_lo` out 1: low-side gate.
- `fault` out 1: overcurrent fault latched.
- `period_start` out 1: one-cycle pulse in period cycle 0.

## Operation
- States: IDLE, RUN, FAULT.
- IDLE→RUN when `en`=1. The first period begins in the next cycle (p=0).
- RUN→IDLE when `en`=0. Gates are 0 from the next cycle.
- Any state→FAULT on a trip. Trip condition: `i_vld` && |`i_smp`| > `oc_lim`.
  - |`i_smp`| is computed in IW bits unsigned, so −2^(IW−1) gives 2^(IW−1).
- FAULT→IDLE on `fault_clr`, unless a trip occurs in the same cycle. A trip wins.
- A trip has priority over `en`.
- Period index p runs 0..PERIOD−1 in RUN, wraps to 0, and is reset to 0 on entry to RUN.
- Gate decode (arithmetic done in CW+1 bits):
  - `gate_hi` = RUN && DEAD ≤ p < D.
  - `gate_lo` = RUN && D+DEAD ≤ p < PERIOD.
  - D is the active duty.
- Because p=0..DEAD−1 is always both-off, dead time at the period wrap is inherent.
- D=0: high side never on. D=PERIOD: low side never on. D < DEAD: no high-side pulse.
- Duty handshake:
  - `duty_rdy`=1 when the shadow register is empty.
  - A transfer (`duty_vld` && `duty_rdy`) loads the shadow, clamped to min(duty, PERIOD), and marks it full.
  - `duty_vld` while `duty_rdy`=0 is ignored. The source must hold it.
- Shadow→D when the shadow is full, in cycle p=PERIOD−1 of RUN or on the IDLE→RUN transition. The shadow is then marked empty.
- A transfer in cycle p=PERIOD−1 is not bypassed into D; it waits for the next boundary.
- `gate_hi` && `gate_lo` must never be 1 in the same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `gate_hi`=0, `gate_lo`=0, `fault`=0, `period_start`=0, `duty_rdy`=1.
  - D=0, shadow empty, state IDLE.
- `rst` mid-operation forces the gates low asynchronously.
- Trip latency: with a tripping sample in cycle t, `fault`=1 and both gates are 0 in cycle t+1.
- `fault` stays 1 until the cycle after an accepted `fault_clr`.
- `duty_rdy` falls in the cycle after a transfer. It rises in the cycle after the shadow→D copy.
- A new D governs gates from p=0 of the following period.
- `period_start`=1 exactly in p=0.

## Structure
- Package `half_bridge_pkg`: state enum (IDLE/RUN/FAULT) and a parameter-check helper for the PERIOD/DEAD/CW constraints.
- Sub-module `oc_detect`: registered-free abs-compare of `i_smp` vs `oc_lim`, producing the trip strobe. It is reusable by the loop's current limiter.
- Top level holds the FSM, period counter, shadow/active duty, and gate decode registers.

## Test plan
Default parameters PERIOD=100, DEAD=4 unless stated.
- **Nominal duty:** load duty=50, then `en`=1.
  - `gate_hi` for p=4..49, `gate_lo` for p=54..99.
  - `period_start` every 100 cycles.
  - Gates never overlap.
- **Mid-period update:** duty=30 accepted at p=20 while D=50.
  - `duty_rdy`=0 until the cycle after p=99.
  - Current period keeps `gate_hi` to p=49; next period `gate_hi` is p=4..29.
- **Limits and clamp:** duty=0 gives `gate_lo` p=4..99 and `gate_hi` never; duty=150 is clamped to 100.
  - A 100→0 boundary shows `gate_hi` off after p=99, then both off p=0..3.
  - `gate_lo` first asserts at p=4.
- **Overcurrent:** `oc_lim`=1000 with `i_smp`=−2048 and `i_vld`=1 at p=10.
  - Next cycle: `fault`=1, gates 0.
  - `en` held 1 keeps FAULT.
  - `fault_clr` with a simultaneous trip stays in FAULT.
  - `fault_clr` alone exits to IDLE, then RUN restarts at p=0.
- **Control interruptions:** `en`=0 at p=60 gives gates 0 next cycle.
  - `rst` pulse at p=30 drops the gates immediately.
  - After reset all outputs are at reset values, D=0, `duty_rdy`=1.
